// File: rtl/aeolus_multicycle_core.sv
// Multi-cycle Aeolus accumulator CPU: external ROM fetch over req/valid,
// bit-serial shifter, run/idle/halt control and parametrised datapath width.
`timescale 1ns/1ps
module aeolus_multicycle_core #(
    parameter int DATA_W = 8,
    parameter int IN_W   = 4,
    parameter int ADDR_W = 8,
    parameter int WRAP   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [2*IN_W-1:0]   switches,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic                rom_req,
    input  logic [7:0]          rom_data,
    input  logic                rom_valid,
    output logic [DATA_W-1:0]   cpu_out,
    output logic                sf,
    output logic                of,
    output logic                busy,
    output logic                halted,
    output logic [2:0]          fsm_state
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [IN_W-1:0]   a, b;
    logic [DATA_W-1:0] o_reg, acc, sr;
    logic [7:0]        ir;
    logic [3:0]        cnt;
    logic              req_hold;

    logic [DATA_W-1:0] a_ext, b_ext;
    logic [DATA_W:0]   sum_ab, diff_ab, sum_acc_a, sum_acc_sr;
    logic              pc_last;
    logic [ADDR_W-1:0] pc_adv;
    logic [2:0]        state_adv;

    assign a_ext      = DATA_W'(a);
    assign b_ext      = DATA_W'(b);
    assign sum_ab     = {1'b0, a_ext} + {1'b0, b_ext};
    assign diff_ab    = {1'b0, a_ext} - {1'b0, b_ext};
    assign sum_acc_a  = {1'b0, acc} + {1'b0, a_ext};
    assign sum_acc_sr = {1'b0, acc} + {1'b0, sr};

    // Past the last address: either wrap to 0 or freeze PC and halt.
    assign pc_last   = (pc == {ADDR_W{1'b1}});
    assign pc_adv    = (pc_last && WRAP == 0) ? pc : pc + ADDR_W'(1);
    assign state_adv = (pc_last && WRAP == 0) ? HALT : FETCH;

    // rom_req follows run only on the first FETCH cycle, then holds until valid.
    assign rom_req   = (state == FETCH) && (req_hold || run);
    assign rom_addr  = pc;
    assign cpu_out   = o_reg;
    assign busy      = (state == FETCH) || (state == EXEC) || (state == SHIFT);
    assign halted    = (state == HALT);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= '0;
            a        <= '0;
            b        <= '0;
            o_reg    <= '0;
            acc      <= '0;
            sr       <= '0;
            ir       <= '0;
            cnt      <= '0;
            sf       <= 1'b0;
            of       <= 1'b0;
            req_hold <= 1'b0;
        end else begin
            case (state)
                IDLE: if (run) state <= FETCH;
                FETCH: begin
                    if (!rom_req) begin
                        state <= IDLE;
                    end else if (rom_valid) begin
                        ir       <= rom_data;
                        req_hold <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        req_hold <= 1'b1;
                    end
                end
                EXEC: begin
                    if (ir[7:4] == 4'd5 || ir[7:4] == 4'd6) begin
                        cnt   <= (ir[3:0] == 4'd0) ? 4'd1 : ir[3:0];
                        state <= SHIFT;
                    end else begin
                        pc    <= pc_adv;
                        state <= state_adv;
                    end
                    case (ir[7:4])
                        4'd0:  a <= switches[2*IN_W-1:IN_W];
                        4'd1:  b <= switches[IN_W-1:0];
                        4'd2:  o_reg <= acc;
                        4'd3:  begin sr <= a_ext; sf <= 1'b0; end
                        4'd4:  begin sr <= b_ext; sf <= 1'b0; end
                        4'd7:  begin acc <= '0; of <= 1'b0; end
                        4'd8:  if (sf) begin acc <= sum_acc_a[DATA_W-1:0]; of <= sum_acc_a[DATA_W]; end
                        4'd9:  if (sf) begin acc <= sum_acc_sr[DATA_W-1:0]; of <= sum_acc_sr[DATA_W]; end
                        4'd10: begin acc <= sum_ab[DATA_W-1:0]; of <= sum_ab[DATA_W]; end
                        4'd11: begin acc <= diff_ab[DATA_W-1:0]; of <= diff_ab[DATA_W]; end
                        4'd12: acc <= a_ext & b_ext;
                        4'd13: acc <= a_ext | b_ext;
                        4'd14: acc <= a_ext ^ b_ext;
                        4'd15: acc <= ~a_ext;
                        default: ;
                    endcase
                end
                SHIFT: begin
                    if (ir[7:4] == 4'd5) begin
                        sr <= sr << 1;
                        sf <= sr[DATA_W-1];
                    end else begin
                        sr <= sr >> 1;
                        sf <= sr[0];
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        pc    <= pc_adv;
                        state <= state_adv;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aeolus_multicycle_core.sv
// Directed bench for aeolus_multicycle_core: hand-computed programs on a default
// instance plus two ADDR_W=2 instances covering halt and wrap at end of program.
`timescale 1ns/1ps
module tb_aeolus_multicycle_core;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       run_s = 1'b0;
    logic [7:0] switches = 8'h00;
    logic       valid_en = 1'b1;
    logic       one = 1'b1;
    logic [7:0] zero_sw = 8'h00;
    logic [7:0] clr_op = 8'h70;
    logic [7:0] rom_mem [0:255];

    logic [7:0] rom_addr, rom_data, cpu_out;
    logic       rom_req, sf, of, busy, halted;
    logic [2:0] fsm_state;

    logic [1:0] h_addr, w_addr;
    logic [7:0] h_out, w_out;
    logic       h_req, h_sf, h_of, h_busy, h_halted;
    logic       w_req, w_sf, w_of, w_busy, w_halted;
    logic [2:0] h_state, w_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];

    aeolus_multicycle_core dut (
        .clk(clk), .reset(reset), .run(run), .switches(switches),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_data(rom_data), .rom_valid(valid_en),
        .cpu_out(cpu_out), .sf(sf), .of(of), .busy(busy), .halted(halted), .fsm_state(fsm_state)
    );

    aeolus_multicycle_core #(.ADDR_W(2), .WRAP(0)) dut_h (
        .clk(clk), .reset(reset), .run(run_s), .switches(zero_sw),
        .rom_addr(h_addr), .rom_req(h_req), .rom_data(clr_op), .rom_valid(one),
        .cpu_out(h_out), .sf(h_sf), .of(h_of), .busy(h_busy), .halted(h_halted), .fsm_state(h_state)
    );

    aeolus_multicycle_core #(.ADDR_W(2), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .run(run_s), .switches(zero_sw),
        .rom_addr(w_addr), .rom_req(w_req), .rom_data(clr_op), .rom_valid(one),
        .cpu_out(w_out), .sf(w_sf), .of(w_of), .busy(w_busy), .halted(w_halted), .fsm_state(w_state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        run_s = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'h70;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cnt;

        // Program 1: A=3, B=5 -> LDA, LDB, ADD, LDO
        clear_rom();
        rom_mem[0] = 8'h00; rom_mem[1] = 8'h10; rom_mem[2] = 8'hA0; rom_mem[3] = 8'h20;
        switches = 8'h35;
        do_reset();
        check("rst_state", fsm_state, S_IDLE);
        check("rst_out", cpu_out, 8'h00);
        check("rst_req", rom_req, 1'b0);
        check("rst_addr", rom_addr, 8'h00);
        check("rst_flags", {sf, of, busy, halted}, 4'b0000);
        run = 1'b1;
        step(1);
        check("p1_fetch", fsm_state, S_FETCH);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (busy) busy_cnt++;
        end
        check("p1_busy_cycles", busy_cnt, 8);
        check("p1_out", cpu_out, 8'h08);
        check("p1_of", of, 1'b0);
        check("p1_addr", rom_addr, 8'h04);
        run = 1'b0;
        step(1);
        check("p1_idle", fsm_state, S_IDLE);

        // Program 2: A=9 -> LDA, LDSA, LSH5, SNZS, LDO
        clear_rom();
        rom_mem[0] = 8'h00; rom_mem[1] = 8'h30; rom_mem[2] = 8'h55;
        rom_mem[3] = 8'h90; rom_mem[4] = 8'h20;
        switches = 8'h90;
        do_reset();
        run = 1'b1;
        step(1);
        step(4);
        check("p2_pre_lsh_addr", rom_addr, 8'h02);
        step(2);
        check("p2_in_shift", fsm_state, S_SHIFT);
        step(4);
        check("p2_still_shift", fsm_state, S_SHIFT);
        step(1);
        check("p2_shift_done", fsm_state, S_FETCH);
        check("p2_addr", rom_addr, 8'h03);
        check("p2_sf", sf, 1'b1);
        step(4);
        check("p2_out", cpu_out, 8'h20);

        // LSH(0) is exactly one step: LDA, LDSA, LSH4, LSH0, SNZS, LDO
        clear_rom();
        rom_mem[0] = 8'h00; rom_mem[1] = 8'h30; rom_mem[2] = 8'h54;
        rom_mem[3] = 8'h50; rom_mem[4] = 8'h90; rom_mem[5] = 8'h20;
        do_reset();
        run = 1'b1;
        step(1);
        step(10);
        check("lsh4_addr", rom_addr, 8'h03);
        check("lsh4_sf", sf, 1'b0);
        step(3);
        check("lsh0_one_step", {fsm_state, rom_addr}, {S_FETCH, 8'h04});
        check("lsh0_sf", sf, 1'b1);
        step(4);
        check("lsh0_out", cpu_out, 8'h20);

        // Program 3: A=5, B=2 -> RSH1 gives sf=0, SNZA skipped
        clear_rom();
        rom_mem[0] = 8'h00; rom_mem[1] = 8'h10; rom_mem[2] = 8'h40;
        rom_mem[3] = 8'h61; rom_mem[4] = 8'h80; rom_mem[5] = 8'h20;
        switches = 8'h52;
        do_reset();
        run = 1'b1;
        step(1);
        step(9);
        check("rsh_b2_sf", sf, 1'b0);
        check("rsh_b2_addr", rom_addr, 8'h04);
        step(2);
        check("snza_skip_2cyc", {fsm_state, rom_addr}, {S_FETCH, 8'h05});
        step(2);
        check("snza_skip_out", cpu_out, 8'h00);

        // B=3 -> sf=1, SR=1: SNZA adds A, SNZS adds SR
        rom_mem[5] = 8'h90; rom_mem[6] = 8'h20;
        switches = 8'h53;
        do_reset();
        run = 1'b1;
        step(1);
        step(9);
        check("rsh_b3_sf", sf, 1'b1);
        step(6);
        check("rsh_b3_out", cpu_out, 8'h06);
        check("rsh_b3_addr", rom_addr, 8'h07);

        // Program 4: SUB borrow, CLR, INV
        clear_rom();
        rom_mem[0] = 8'h00; rom_mem[1] = 8'h10; rom_mem[2] = 8'hB0; rom_mem[3] = 8'h20;
        rom_mem[4] = 8'h70; rom_mem[5] = 8'h20; rom_mem[6] = 8'h00; rom_mem[7] = 8'hF0;
        rom_mem[8] = 8'h20;
        switches = 8'h12;
        do_reset();
        run = 1'b1;
        step(1);
        step(8);
        check("sub_out", cpu_out, 8'hFF);
        check("sub_of", of, 1'b1);
        switches = 8'h32;
        step(4);
        check("clr_out", cpu_out, 8'h00);
        check("clr_of", of, 1'b0);
        step(6);
        check("inv_out", cpu_out, 8'hFC);

        // Delayed rom_valid: request held stable even after run drops
        clear_rom();
        rom_mem[0] = 8'h00; rom_mem[1] = 8'hF0; rom_mem[2] = 8'h20;
        switches = 8'h70;
        valid_en = 1'b0;
        do_reset();
        run = 1'b1;
        step(1);
        step(1);
        run = 1'b0;
        step(2);
        check("hs_wait_req", {rom_req, rom_addr}, {1'b1, 8'h00});
        check("hs_wait_state", fsm_state, S_FETCH);
        check("hs_wait_out", cpu_out, 8'h00);
        valid_en = 1'b1;
        step(1);
        check("hs_exec", fsm_state, S_EXEC);
        step(1);
        check("hs_run_low_req", {rom_req, rom_addr}, {1'b0, 8'h01});
        step(1);
        check("hs_back_idle", fsm_state, S_IDLE);
        run = 1'b1;
        step(1);
        step(4);
        check("hs_resume_out", cpu_out, 8'hF8);

        // Reset during SHIFT of LSH(8)
        clear_rom();
        rom_mem[0] = 8'h00; rom_mem[1] = 8'hF0; rom_mem[2] = 8'h20;
        rom_mem[3] = 8'h30; rom_mem[4] = 8'h58;
        switches = 8'h90;
        do_reset();
        run = 1'b1;
        step(1);
        step(6);
        check("mid_out_before", cpu_out, 8'hF6);
        step(2);
        step(3);
        check("mid_in_shift", fsm_state, S_SHIFT);
        reset = 1'b0;
        step(1);
        check("mid_rst_state", fsm_state, S_IDLE);
        check("mid_rst_out", {cpu_out, rom_addr}, 16'h0000);
        check("mid_rst_ctl", {rom_req, busy, halted, sf, of}, 5'b00000);
        reset = 1'b1;
        run = 1'b0;

        // End of program on ADDR_W=2 instances: four CLRs
        do_reset();
        run_s = 1'b1;
        step(1);
        step(7);
        check("eop_4th_exec", {h_state, h_addr}, {S_EXEC, 2'd3});
        check("eop_not_halted", h_halted, 1'b0);
        step(1);
        check("eop_halted", {h_halted, h_busy, h_req}, 3'b100);
        check("eop_pc_hold", h_addr, 2'd3);
        check("wrap_addr0", {w_state, w_addr}, {S_FETCH, 2'd0});
        step(3);
        check("eop_stays", {h_state, h_req, h_addr}, {S_HALT, 1'b0, 2'd3});
        run_s = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end
endmodule
